audio_sample_packer: RTL and testbench
======================================

# audio_sample_packer

Builds HDMI Audio Sample Packets (packet type 0x02, 2-channel layout 0) from a stream of stereo PCM samples in the pixel clock domain. Sits directly upstream of the data-island packet assembler: it buffers up to four sample pairs and presents a complete 24-bit header plus four 56-bit subpackets, holding them stable until the packet scheduler takes them at a packet boundary. It tags IEC 60958 block-start (B), channel-status (C), user (U), validity (V) and even-parity (P) bits per sample.

## Interface
- SAMPLE_WIDTH, 16, PCM bits per channel; legal range 16..24; left-justified into 24 bits, LSBs zero-padded.
- FIFO_DEPTH, 4, sample-pair buffer depth; power of two, ≥4.
- clk_pixel  in  1  pixel clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; a new pair is on sample_l/sample_r.
- sample_l  in  SAMPLE_WIDTH  left channel, two's complement.
- sample_r  in  SAMPLE_WIDTH  right channel, two's complement.
- channel_status  in  192  IEC 60958 channel-status block; bit k is sent in frame k (same bit for L and R).
- packet_take  in  1  one-cycle strobe from the scheduler; consume the presented packet.
- packet_ready  out  1  a packet holding ≥1 sample is presented.
- header  out  24  {HB2, HB1, HB0}, as the assembler expects.
- sub  out  56 × [3:0]  subpackets 0..3.
- overflow  out  1  sticky overflow flag (see Configuration).

## Operation
- Enqueue: on sample_valid with FIFO not full, store {sample_l, sample_r, frame_idx, C=channel_status[frame_idx]}; frame_idx 0..191 increments per accepted pair and wraps 191→0. B is set for frame_idx==0. V=0, U=0.
- FIFO full plus sample_valid without packet_take in the same cycle: drop the sample. frame_idx does not advance.
- Presentation register: when packet_take is asserted and FIFO count>0, pop n=min(count,4) entries into subpackets 0..n-1. Zero subpackets n..3.
- HB0=8'h02. HB1={3'b000, layout=0, sample_present[3:0]}, where bit i=1 for i<n. HB2={B[3:0], sample_flat[3:0]=0}, where B[i]=B bit of subpacket i.
- Subpacket i: bytes 0..2 = left 24-bit, bytes 3..5 = right 24-bit, byte 6 = {P_R, C_R, U_R, V_R, P_L, C_L, U_L, V_L}.
- P_x = even parity over the 24 sample bits plus V, U and C of that channel.
- packet_take while count==0: ignore it. Header and sub are unchanged.
- Simultaneous sample_valid and packet_take: the pop uses only entries present before the edge. The new pair is enqueued after the pop. When full, the pop frees space, so the new pair is accepted, not dropped.

## Timing
- Reset values: packet_ready=0, header=24'h0, all sub=56'h0, overflow=0, FIFO empty, frame_idx=0.
- Assertion of reset mid-packet clears everything immediately (asynchronous). The presented packet is lost.
- Enqueue latency: a pair accepted at edge t can be popped by a packet_take sampled at edge t+1.
- Pop latency: header, sub and packet_ready update at the edge that samples packet_take. They stay stable until the next effective take.
- packet_ready is registered. It equals (FIFO count after the update > 0) OR (the presented packet has not yet been taken).
- The scheduler must only assert packet_take while packet_ready=1 and outside an active data-island period.

## Configuration
- AUDIO_PACKER_OVERFLOW_EN defined: overflow is set at the first dropped sample and stays set until reset. Also include an internal 16-bit saturating drop counter for debug, readable via hierarchical reference.
- Not defined: overflow is tied to 0, there is no drop counter, and the drop logic is still present.

## Structure
- Shared package audio_pkg:
  - AUDIO_SAMPLE_PACKET_TYPE = 8'h02
  - IEC_BLOCK_FRAMES = 192
  - typedef struct audio_entry_t {left[23:0], right[23:0], b, c}
  - function even_parity24
- Sub-module audio_sample_fifo: parameterised depth, simultaneous push/pop, count output. The packer holds the frame counter, the pop/format logic and the presentation registers.

## Test plan
- Reset, then one pair L=16'h1234, R=16'h8000 at frame 0, then take:
  - header = 24'h100102 (B0=1, sp=0001)
  - sub[0] bytes 0..2 = 12 34 00 → sub[0][23:0] = 24'h003412
  - sub[1..3] = 0, packet_ready stays 0 after take.
- Five pairs enqueued, then take: sp=1111 and packet_ready remains 1. A second take gives sp=0001 containing pair 5.
- 193 pairs with channel_status[0]=1 and the rest 0: B and C are set on frames 0 and 192 only.
- Parity: L=16'h0001, with C=1 at that frame → P_L=0 (two ones). L=16'h0003, C=1 → P_L=1.
- FIFO full plus sample_valid:
  - without take: the pair is dropped and overflow=1 (with macro); frame_idx is unchanged.
  - with take in the same cycle: the pair is accepted.
- Asserting reset between enqueue and take: all outputs return to reset values within the same cycle. The next packet starts at frame 0 with B=1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the HDMI audio sample packer.
// Contents: packet type code, IEC 60958 block length, FIFO entry payload,
// and a 24-bit even-parity helper.
package audio_pkg;

  localparam logic [7:0]  AUDIO_SAMPLE_PACKET_TYPE = 8'h02;
  localparam int unsigned IEC_BLOCK_FRAMES         = 192;
  localparam int unsigned PCM24_W                  = 24;
  localparam int unsigned SUBPKT_W                 = 56;
  localparam int unsigned NUM_SUBPKT               = 4;
  localparam int unsigned FRAME_IDX_W              = 8;
  localparam int unsigned POP_CNT_W                = 3;

  // One buffered stereo frame: left-justified samples plus block-start and channel-status bits
  typedef struct packed {
    logic [PCM24_W-1:0] left;
    logic [PCM24_W-1:0] right;
    logic               b;
    logic               c;
  } audio_entry_t;

  // XOR-reduction of a 24-bit sample; XOR in V/U/C to get the IEC parity bit
  function automatic logic even_parity24(input logic [PCM24_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Sample-pair FIFO with single push and multi-entry (0..4) pop per cycle.
// The four oldest entries are exposed combinationally so the packer can
// format a whole packet in one edge.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_data   write one entry (caller guarantees space after the pop)
//   i_pop_cnt        number of entries to retire this edge (0..4, <= count)
//   o_peek_c         oldest four entries, combinational (valid below count)
//   o_count          registered occupancy
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  audio_entry_t                 i_data,
  input  logic [POP_CNT_W-1:0]         i_pop_cnt,
  output audio_entry_t [NUM_SUBPKT-1:0] o_peek_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  audio_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // Storage array, no reset needed: occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_cnt);
      o_count  <= o_count + CNT_W'(i_push) - CNT_W'(i_pop_cnt);
    end
  end

  // Oldest four entries in age order
  always_comb begin
    o_peek_c = '0;
    for (int i = 0; i < int'(NUM_SUBPKT); i++) begin
      o_peek_c[i] = r_mem[PTR_W'(r_rd_ptr + PTR_W'(i))];
    end
  end

endmodule

// File: rtl/audio_sample_packer.sv
// HDMI Audio Sample Packet builder (type 0x02, 2-channel layout 0).
// Buffers stereo PCM pairs, tags IEC 60958 B/C/U/V/P bits and presents a
// header plus four subpackets that stay stable until the scheduler takes them.
// Optional feature macro: AUDIO_PACKER_OVERFLOW_EN (sticky overflow flag and
// 16-bit saturating drop counter r_drop_cnt).
// Ports:
//   clk_pixel, reset              pixel clock, asynchronous active-high reset
//   sample_valid, sample_l/_r     new stereo pair strobe and data
//   channel_status                192-bit IEC channel-status block
//   packet_take                   scheduler consumes the presented packet
//   packet_ready                  a non-empty packet can be presented
//   header                        {HB2, HB1, HB0}
//   sub                           subpackets 0..3
//   overflow                      sticky drop indication (macro only)
module audio_sample_packer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk_pixel,
  input  logic                               reset,
  input  logic                               sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]            sample_l,
  input  logic [SAMPLE_WIDTH-1:0]            sample_r,
  input  logic [IEC_BLOCK_FRAMES-1:0]        channel_status,
  input  logic                               packet_take,
  output logic                               packet_ready,
  output logic [23:0]                        header,
  output logic [NUM_SUBPKT-1:0][SUBPKT_W-1:0] sub,
  output logic                               overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  logic [FRAME_IDX_W-1:0]          r_frame_idx;
  audio_entry_t                    w_entry;
  audio_entry_t [NUM_SUBPKT-1:0]   w_peek;
  logic [CNT_W-1:0]                w_count;
  logic [CNT_W-1:0]                w_count_next;
  logic                            w_full;
  logic                            w_take;
  logic                            w_push;
  logic [POP_CNT_W-1:0]            w_pop_cnt;
  logic [NUM_SUBPKT-1:0]           w_sp;
  logic [NUM_SUBPKT-1:0]           w_b;
  logic [NUM_SUBPKT-1:0][SUBPKT_W-1:0] w_sub_next;

  // Subpacket layout: MSB byte of each sample first, status byte last; V=U=0
  function automatic logic [SUBPKT_W-1:0] fmt_sub(input audio_entry_t e);
    logic p_l;
    logic p_r;
    p_l = even_parity24(e.left)  ^ e.c;
    p_r = even_parity24(e.right) ^ e.c;
    return {p_r, e.c, 1'b0, 1'b0, p_l, e.c, 1'b0, 1'b0,
            e.right[7:0], e.right[15:8], e.right[23:16],
            e.left[7:0],  e.left[15:8],  e.left[23:16]};
  endfunction

  // A take pops whatever existed before the edge; a pop always frees room for a same-cycle push
  assign w_full       = (w_count == CNT_W'(FIFO_DEPTH));
  assign w_take       = packet_take && (w_count != '0);
  assign w_pop_cnt    = !w_take                    ? '0 :
                        (w_count >= CNT_W'(NUM_SUBPKT)) ? POP_CNT_W'(NUM_SUBPKT) :
                                                     POP_CNT_W'(w_count);
  assign w_push       = sample_valid && (!w_full || w_take);
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop_cnt);

  // Left-justify into 24 bits and tag with this frame's B and C bits
  always_comb begin
    w_entry       = '0;
    w_entry.left  = PCM24_W'(sample_l) << (PCM24_W - SAMPLE_WIDTH);
    w_entry.right = PCM24_W'(sample_r) << (PCM24_W - SAMPLE_WIDTH);
    w_entry.b     = (r_frame_idx == '0);
    w_entry.c     = channel_status[r_frame_idx];
  end

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk_pixel),
    .i_rst     (reset),
    .i_push    (w_push),
    .i_data    (w_entry),
    .i_pop_cnt (w_pop_cnt),
    .o_peek_c  (w_peek),
    .o_count   (w_count)
  );

  // Frame counter advances only on accepted pairs
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_frame_idx <= '0;
    end else if (w_push) begin
      r_frame_idx <= (r_frame_idx == FRAME_IDX_W'(IEC_BLOCK_FRAMES - 1)) ?
                     '0 : r_frame_idx + FRAME_IDX_W'(1);
    end
  end

  // Next packet contents: populated slots first, remainder zeroed
  always_comb begin
    w_sp       = '0;
    w_b        = '0;
    w_sub_next = '0;
    for (int i = 0; i < int'(NUM_SUBPKT); i++) begin
      if (POP_CNT_W'(i) < w_pop_cnt) begin
        w_sp[i]       = 1'b1;
        w_b[i]        = w_peek[i].b;
        w_sub_next[i] = fmt_sub(w_peek[i]);
      end
    end
  end

  // Presentation registers update only on an effective take
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      header       <= '0;
      sub          <= '0;
      packet_ready <= 1'b0;
    end else begin
      packet_ready <= (w_count_next != '0);
      if (w_take) begin
        header <= {w_b, 4'b0000, 3'b000, 1'b0, w_sp, AUDIO_SAMPLE_PACKET_TYPE};
        sub    <= w_sub_next;
      end
    end
  end

`ifdef AUDIO_PACKER_OVERFLOW_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = sample_valid && w_full && !w_take;

  // Sticky flag plus saturating debug counter of dropped pairs
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_packer.sv
// Directed self-checking bench for audio_sample_packer (FIFO_DEPTH=8).
module tb_audio_sample_packer;

  logic         clk_pixel = 1'b0;
  logic         reset;
  logic         sample_valid;
  logic [15:0]  sample_l;
  logic [15:0]  sample_r;
  logic [191:0] channel_status;
  logic         packet_take;
  logic         packet_ready;
  logic [23:0]  header;
  logic [3:0][55:0] sub;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

`ifdef AUDIO_PACKER_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  always #5 clk_pixel = ~clk_pixel;

  audio_sample_packer #(
    .SAMPLE_WIDTH (16),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .channel_status (channel_status),
    .packet_take    (packet_take),
    .packet_ready   (packet_ready),
    .header         (header),
    .sub            (sub),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic tk);
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    packet_take  = tk;
    tick();
    sample_valid = 1'b0;
    packet_take  = 1'b0;
  endtask

  task automatic take;
    packet_take = 1'b1;
    tick();
    packet_take = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hdr"}, 64'(header), 64'h0);
    for (int i = 0; i < 4; i++) check({tag, "_sub"}, 64'(sub[i]), 64'h0);
    check({tag, "_rdy"}, 64'(packet_ready), 64'h0);
    check({tag, "_ovf"}, 64'(overflow), 64'h0);
    check({tag, "_fidx"}, 64'(dut.r_frame_idx), 64'h0);
  endtask

  initial begin
    reset          = 1'b1;
    sample_valid   = 1'b0;
    sample_l       = '0;
    sample_r       = '0;
    channel_status = '0;
    packet_take    = 1'b0;
    tick();
    tick();
    check_idle("rst");
    reset = 1'b0;
    tick();

    // Single pair at frame 0, then take, then take on empty
    push(16'h1234, 16'h8000, 1'b0);
    check("t1_rdy_pre", 64'(packet_ready), 64'h1);
    take();
    check("t1_hdr", 64'(header), 64'h100102);
    check("t1_sub0", 64'(sub[0]), 64'h88000080003412);
    for (int i = 1; i < 4; i++) check("t1_subn", 64'(sub[i]), 64'h0);
    check("t1_rdy", 64'(packet_ready), 64'h0);
    take();
    check("t1_empty_hdr", 64'(header), 64'h100102);
    check("t1_empty_sub0", 64'(sub[0]), 64'h88000080003412);
    check("t1_empty_rdy", 64'(packet_ready), 64'h0);

    // Five pairs: full packet then remainder
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'(i), 16'h0000, 1'b0);
    take();
    check("t2_hdr", 64'(header), 64'h100F02);
    check("t2_sub0", 64'(sub[0]), 64'h08000000000100);
    check("t2_sub1", 64'(sub[1]), 64'h08000000000200);
    check("t2_sub2", 64'(sub[2]), 64'h00000000000300);
    check("t2_sub3", 64'(sub[3]), 64'h08000000000400);
    check("t2_rdy", 64'(packet_ready), 64'h1);
    take();
    check("t2b_hdr", 64'(header), 64'h000102);
    check("t2b_sub0", 64'(sub[0]), 64'h00000000000500);
    check("t2b_sub1", 64'(sub[1]), 64'h0);
    check("t2b_rdy", 64'(packet_ready), 64'h0);

    // Parity with C=1
    do_reset();
    channel_status    = '0;
    channel_status[0] = 1'b1;
    channel_status[1] = 1'b1;
    push(16'h0001, 16'h0000, 1'b0);
    push(16'h0003, 16'h0000, 1'b0);
    take();
    check("t3_hdr", 64'(header), 64'h100302);
    check("t3_sub0", 64'(sub[0]), 64'hC4000000000100);
    check("t3_sub1", 64'(sub[1]), 64'hCC000000000300);

    // 193 frames: B and C only on frames 0 and 192
    do_reset();
    channel_status    = '0;
    channel_status[0] = 1'b1;
    for (int f = 0; f <= 192; f++) begin
      logic hit;
      hit = (f == 0) || (f == 192);
      push(16'h0000, 16'h0000, 1'b0);
      take();
      check($sformatf("t4_frame%0d", f), {32'h0, header, sub[0][55:48]},
            {32'h0, (hit ? 24'h100102 : 24'h000102), (hit ? 8'hCC : 8'h00)});
    end

    // Full FIFO: drop without take, accept with take
    do_reset();
    channel_status = '0;
    for (int i = 0; i < 8; i++) push(16'h0000, 16'h0000, 1'b0);
    check("t5_rdy_full", 64'(packet_ready), 64'h1);
    push(16'hDEAD, 16'h0000, 1'b0);
    check("t5_drop_fidx", 64'(dut.r_frame_idx), 64'd8);
    check("t5_ovf", 64'(overflow), 64'(EXP_OVF));
`ifdef AUDIO_PACKER_OVERFLOW_EN
    check("t5_dropcnt", 64'(dut.r_drop_cnt), 64'd1);
`endif
    push(16'hBEEF, 16'h0000, 1'b1);
    check("t5_sim_hdr", 64'(header), 64'h100F02);
    check("t5_sim_fidx", 64'(dut.r_frame_idx), 64'd9);
    check("t5_sim_rdy", 64'(packet_ready), 64'h1);
    take();
    check("t5_t2_hdr", 64'(header), 64'h000F02);
    check("t5_t2_rdy", 64'(packet_ready), 64'h1);
    take();
    check("t5_t3_hdr", 64'(header), 64'h000102);
    check("t5_t3_sub0", 64'(sub[0]), 64'h0800000000EFBE);
    check("t5_t3_sub1", 64'(sub[1]), 64'h0);
    check("t5_t3_rdy", 64'(packet_ready), 64'h0);
    check("t5_ovf_sticky", 64'(overflow), 64'(EXP_OVF));

    // Asynchronous reset between enqueue and take
    do_reset();
    push(16'h1234, 16'h8000, 1'b0);
    take();
    check("t6_pre_hdr", 64'(header), 64'h100102);
    push(16'h0005, 16'h0000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t6_async");
    tick();
    reset = 1'b0;
    tick();
    push(16'h1234, 16'h8000, 1'b0);
    take();
    check("t6_post_hdr", 64'(header), 64'h100102);
    check("t6_post_sub0", 64'(sub[0]), 64'h88000080003412);
    check("t6_post_rdy", 64'(packet_ready), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
